cam_sched: RTL and testbench

Two-port scheduler and slot manager for the 16-entry, 8-bit content-addressable memory. It arbitrates lookup, insert and delete requests from two requesters onto the single CAM port, and sequences each operation as a lookup, an optional write, then a response. It owns slot allocation through a valid bitmap. After every reset it fills all entries with a reserved key, so uninitialised contents can never match.

---
 rtl/cam_sched_if.sv | 30 +++
 rtl/cam_sched.sv | 207 ++++++++++++++++++++
 tb/tb_cam_sched.sv | 325 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/cam_sched_if.sv
// Request/response bundle between the two requesters and the cam_sched
// scheduler. The scheduler is the slave and the requesters are the master.
interface cam_sched_if;
  logic       req0_valid;
  logic [1:0] req0_op;
  logic [7:0] req0_key;
  logic       req0_ready;
  logic       req1_valid;
  logic [1:0] req1_op;
  logic [7:0] req1_key;
  logic       req1_ready;
  logic       rsp_valid;
  logic       rsp_id;
  logic       rsp_hit;
  logic [3:0] rsp_idx;
  logic       rsp_full;
  logic       rsp_err;

  modport master (
    output req0_valid, req0_op, req0_key, req1_valid, req1_op, req1_key,
    input  req0_ready, req1_ready,
    input  rsp_valid, rsp_id, rsp_hit, rsp_idx, rsp_full, rsp_err
  );

  modport slave (
    input  req0_valid, req0_op, req0_key, req1_valid, req1_op, req1_key,
    output req0_ready, req1_ready,
    output rsp_valid, rsp_id, rsp_hit, rsp_idx, rsp_full, rsp_err
  );
endinterface

// File: rtl/cam_sched.sv
// Two-requester scheduler and slot manager for a 16-entry, 8-bit CAM.
// It fills the CAM with a reserved key after reset, then runs each operation as lookup, optional write and response.
module cam_sched #(
  parameter int         NB_MEM   = 16,
  parameter logic [7:0] INIT_KEY = 8'hFF
) (
  input  logic       clk,
  input  logic       rst_n,
  cam_sched_if.slave bus,
  output logic       init_done,
  output logic       cam_enable,
  output logic       cam_write,
  output logic [4:0] cam_addr,
  output logic [7:0] cam_data,
  input  logic [4:0] cam_out,
  input  logic       cam_found
);
  localparam int IDX_W = $clog2(NB_MEM);
  localparam logic [IDX_W:0] FILL_END = (IDX_W+1)'(NB_MEM);

  typedef enum logic [2:0] {S_INIT, S_IDLE, S_LOOK, S_CHECK, S_WRITE, S_RESP} state_t;
  typedef enum logic [1:0] {OP_LOOKUP = 2'b00, OP_INSERT = 2'b01,
                            OP_DELETE = 2'b10, OP_ALIAS  = 2'b11} op_t;

  state_t             state_q, state_d;
  logic [IDX_W:0]     fill_q, fill_d;
  logic               rr_last_q, rr_last_d;
  logic               id_q, id_d;
  op_t                op_q, op_d;
  logic [7:0]         key_q, key_d;
  logic [NB_MEM-1:0]  valid_q, valid_d;
  logic               res_hit_q, res_hit_d, res_full_q, res_full_d, res_err_q, res_err_d;
  logic [IDX_W-1:0]   res_idx_q, res_idx_d;
  logic               init_done_d, cam_enable_d, cam_write_d, rsp_valid_d;
  logic [4:0]         cam_addr_d;
  logic [7:0]         cam_data_d;

  logic               grant0, grant1, cam_hit, free_any;
  logic [IDX_W-1:0]   match_idx, free_idx;
  logic [7:0]         req_key;
  logic [1:0]         req_op;

  // Round-robin: on a tie, the requester not granted last wins.
  assign grant0 = (state_q == S_IDLE) && bus.req0_valid && (!bus.req1_valid || rr_last_q);
  assign grant1 = (state_q == S_IDLE) && bus.req1_valid && !grant0;
  assign bus.req0_ready = grant0;
  assign bus.req1_ready = grant1;
  assign req_key = grant1 ? bus.req1_key : bus.req0_key;
  assign req_op  = grant1 ? bus.req1_op  : bus.req0_op;

  // A match is trusted only if it lands on an allocated slot inside the populated range.
  assign match_idx = cam_out[IDX_W-1:0];
  assign cam_hit   = cam_found && !cam_out[4] && valid_q[match_idx];

  always_comb begin
    free_any = 1'b0;
    free_idx = '0;
    for (int i = NB_MEM - 1; i >= 0; i--) begin
      if (!valid_q[i]) begin
        free_any = 1'b1;
        free_idx = IDX_W'(i);
      end
    end
  end

  // NOTE: every signal is given a default before the case so no path leaves it unassigned and infers a latch.
  always_comb begin
    state_d      = state_q;
    fill_d       = fill_q;
    rr_last_d    = rr_last_q;
    id_d         = id_q;
    op_d         = op_q;
    key_d        = key_q;
    valid_d      = valid_q;
    res_hit_d    = res_hit_q;
    res_idx_d    = res_idx_q;
    res_full_d   = res_full_q;
    res_err_d    = res_err_q;
    init_done_d  = init_done;
    cam_enable_d = 1'b0;
    cam_write_d  = 1'b0;
    cam_addr_d   = '0;
    cam_data_d   = '0;
    case (state_q)
      S_INIT: begin
        if (fill_q == FILL_END) begin
          state_d     = S_IDLE;
          init_done_d = 1'b1;
        end else begin
          cam_write_d = 1'b1;
          cam_addr_d  = 5'(fill_q[IDX_W-1:0]);
          cam_data_d  = INIT_KEY;
          fill_d      = fill_q + 1'b1;
        end
      end
      S_IDLE: begin
        if (grant0 || grant1) begin
          id_d       = grant1;
          rr_last_d  = grant1;
          op_d       = op_t'(req_op);
          key_d      = req_key;
          res_hit_d  = 1'b0;
          res_idx_d  = '0;
          res_full_d = 1'b0;
          res_err_d  = (req_key == INIT_KEY);
          if (req_key == INIT_KEY) begin
            state_d = S_RESP;
          end else begin
            state_d      = S_LOOK;
            cam_enable_d = 1'b1;
            cam_data_d   = req_key;
          end
        end
      end
      S_LOOK: state_d = S_CHECK;
      S_CHECK: begin
        state_d   = S_RESP;
        res_hit_d = cam_hit;
        res_idx_d = cam_hit ? match_idx : '0;
        case (op_q)
          OP_INSERT: begin
            if (!cam_hit) begin
              if (free_any) begin
                res_idx_d   = free_idx;
                state_d     = S_WRITE;
                cam_write_d = 1'b1;
                cam_addr_d  = 5'(free_idx);
                cam_data_d  = key_q;
              end else begin
                res_full_d = 1'b1;
              end
            end
          end
          OP_DELETE: begin
            if (cam_hit) begin
              state_d     = S_WRITE;
              cam_write_d = 1'b1;
              cam_addr_d  = 5'(match_idx);
              cam_data_d  = INIT_KEY;
            end
          end
          default: ;
        endcase
      end
      S_WRITE: begin
        valid_d[res_idx_q] = (op_q == OP_INSERT);
        state_d            = S_RESP;
      end
      S_RESP:  state_d = S_IDLE;
      default: state_d = S_INIT;
    endcase
    rsp_valid_d = (state_d == S_RESP);
  end

  // Outputs are registered from the next state, so they read all-zero while reset is held.
  // NOTE: the valid bitmap is a plain flop vector and clears on reset; the CAM array itself is cleared by the INIT fill.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= S_INIT;
      fill_q        <= '0;
      rr_last_q     <= 1'b1;
      id_q          <= 1'b0;
      op_q          <= OP_LOOKUP;
      key_q         <= '0;
      valid_q       <= '0;
      res_hit_q     <= 1'b0;
      res_idx_q     <= '0;
      res_full_q    <= 1'b0;
      res_err_q     <= 1'b0;
      init_done     <= 1'b0;
      cam_enable    <= 1'b0;
      cam_write     <= 1'b0;
      cam_addr      <= '0;
      cam_data      <= '0;
      bus.rsp_valid <= 1'b0;
      bus.rsp_id    <= 1'b0;
      bus.rsp_hit   <= 1'b0;
      bus.rsp_idx   <= '0;
      bus.rsp_full  <= 1'b0;
      bus.rsp_err   <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments keep every register updating from the same pre-edge values.
      state_q       <= state_d;
      fill_q        <= fill_d;
      rr_last_q     <= rr_last_d;
      id_q          <= id_d;
      op_q          <= op_d;
      key_q         <= key_d;
      valid_q       <= valid_d;
      res_hit_q     <= res_hit_d;
      res_idx_q     <= res_idx_d;
      res_full_q    <= res_full_d;
      res_err_q     <= res_err_d;
      init_done     <= init_done_d;
      cam_enable    <= cam_enable_d;
      cam_write     <= cam_write_d;
      cam_addr      <= cam_addr_d;
      cam_data      <= cam_data_d;
      bus.rsp_valid <= rsp_valid_d;
      bus.rsp_id    <= rsp_valid_d & id_d;
      bus.rsp_hit   <= rsp_valid_d & res_hit_d;
      bus.rsp_idx   <= rsp_valid_d ? res_idx_d : '0;
      bus.rsp_full  <= rsp_valid_d & res_full_d;
      bus.rsp_err   <= rsp_valid_d & res_err_d;
    end
  end
endmodule

// File: tb/tb_cam_sched.sv
// Self-checking bench for cam_sched: behavioural CAM, slot-table reference model,
// directed scenarios followed by randomized traffic.
module tb_cam_sched;
  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       init_done, cam_enable, cam_write;
  logic [4:0] cam_addr;
  logic [7:0] cam_data;
  logic [4:0] cam_out = '0;
  logic       cam_found = 1'b0;

  cam_sched_if bus();

  cam_sched dut (
    .clk(clk), .rst_n(rst_n), .bus(bus), .init_done(init_done),
    .cam_enable(cam_enable), .cam_write(cam_write), .cam_addr(cam_addr),
    .cam_data(cam_data), .cam_out(cam_out), .cam_found(cam_found)
  );

  always #5 clk = ~clk;

  // Behavioural CAM: seeded with stale keys, write on cam_write, registered search on cam_enable.
  logic [7:0] cam_mem [16];
  bit         seeded = 1'b0;
  always @(posedge clk) begin
    if (!seeded) begin
      for (int i = 0; i < 16; i++) cam_mem[i] <= {4'h1, 4'(i)};
      seeded <= 1'b1;
    end else begin
      if (cam_write) cam_mem[cam_addr[3:0]] <= cam_data;
      if (cam_enable) begin
        cam_found <= 1'b0;
        cam_out   <= '0;
        for (int i = 15; i >= 0; i--) begin
          if (cam_mem[i] == cam_data) begin
            cam_found <= 1'b1;
            cam_out   <= 5'(i);
          end
        end
      end
    end
  end

  int   n_cmp = 0;
  int   n_bad = 0;
  bit   slot_used [16];
  logic [7:0] slot_key [16];
  bit   model_last;

  task automatic model_reset();
    for (int i = 0; i < 16; i++) begin
      slot_used[i] = 1'b0;
      slot_key[i]  = 8'h00;
    end
    model_last = 1'b1;
  endtask

  // Reference: a table of occupied slots, predicting fields, latency and CAM activity.
  task automatic model_apply(input logic [1:0] op, input logic [7:0] key,
                             output bit hit, output logic [3:0] idx, output bit full,
                             output bit err, output int lat, output int nen,
                             output int nwr, output logic [7:0] wdata);
    int m, f;
    m = -1; f = -1;
    hit = 1'b0; idx = 4'h0; full = 1'b0; err = 1'b0;
    lat = 3; nen = 1; nwr = 0; wdata = 8'h00;
    if (key == 8'hFF) begin
      err = 1'b1; lat = 1; nen = 0;
      return;
    end
    for (int i = 0; i < 16; i++) begin
      if (slot_used[i] && slot_key[i] == key) m = i;
      if (!slot_used[i] && f < 0) f = i;
    end
    hit = (m >= 0);
    if (hit) idx = 4'(m);
    case (op)
      2'b01: if (!hit) begin
        if (f >= 0) begin
          idx = 4'(f); nwr = 1; lat = 4; wdata = key;
          slot_used[f] = 1'b1; slot_key[f] = key;
        end else begin
          full = 1'b1;
        end
      end
      2'b10: if (hit) begin
        nwr = 1; lat = 4; wdata = 8'hFF;
        slot_used[m] = 1'b0;
      end
      default: ;
    endcase
  endtask

  task automatic drive_req(input bit id, input bit v, input logic [1:0] op, input logic [7:0] key);
    if (id) begin
      bus.req1_valid = v; bus.req1_op = op; bus.req1_key = key;
    end else begin
      bus.req0_valid = v; bus.req0_op = op; bus.req0_key = key;
    end
  endtask

  function automatic logic [26:0] out_pack();
    return {init_done, cam_enable, cam_write, cam_addr, cam_data, bus.rsp_valid, bus.rsp_id,
            bus.rsp_hit, bus.rsp_idx, bus.rsp_full, bus.rsp_err, bus.req0_ready, bus.req1_ready};
  endfunction

  // Called right after the handshake edge; samples each following cycle until rsp_valid.
  task automatic wait_rsp(output int lat, output int n_en, output int n_wr, output bit clash,
                          output logic [4:0] wa, output logic [7:0] wd, output logic [7:0] fields);
    lat = 0; n_en = 0; n_wr = 0; clash = 1'b0; wa = '0; wd = '0; fields = '0;
    for (int c = 1; c <= 12; c++) begin
      @(negedge clk);
      if (cam_enable) n_en++;
      if (cam_write) begin n_wr++; wa = cam_addr; wd = cam_data; end
      if (cam_enable && cam_write) clash = 1'b1;
      if (bus.rsp_valid) begin
        lat = c;
        fields = {bus.rsp_id, bus.rsp_hit, bus.rsp_idx, bus.rsp_full, bus.rsp_err};
        break;
      end
    end
  endtask

  task automatic run_op(input bit id, input logic [1:0] op, input logic [7:0] key, input string tag);
    bit e_hit, e_full, e_err, clash;
    logic [3:0] e_idx;
    logic [7:0] e_wd, wd, fields;
    logic [4:0] wa;
    int e_lat, e_en, e_wr, lat, n_en, n_wr, t;
    @(negedge clk);
    drive_req(id, 1'b1, op, key);
    #1;
    t = 0;
    while (!(id ? bus.req1_ready : bus.req0_ready) && t < 50) begin @(negedge clk); t++; end
    n_cmp++;
    if (t >= 50) begin
      n_bad++;
      $display("FAIL %s handshake: ready not seen within 50 cycles", tag);
      drive_req(id, 1'b0, op, key);
      return;
    end
    model_last = id;
    model_apply(op, key, e_hit, e_idx, e_full, e_err, e_lat, e_en, e_wr, e_wd);
    @(posedge clk);
    #1 drive_req(id, 1'b0, op, key);
    wait_rsp(lat, n_en, n_wr, clash, wa, wd, fields);
    n_cmp++;
    if (fields !== {id, e_hit, e_idx, e_full, e_err}) begin
      n_bad++;
      $display("FAIL %s rsp {id,hit,idx,full,err}: got %b required %b", tag, fields,
               {id, e_hit, e_idx, e_full, e_err});
    end
    n_cmp++;
    if (lat !== e_lat) begin
      n_bad++;
      $display("FAIL %s latency: got H+%0d required H+%0d", tag, lat, e_lat);
    end
    n_cmp++;
    if ({clash, 4'(n_en), 4'(n_wr)} !== {1'b0, 4'(e_en), 4'(e_wr)}) begin
      n_bad++;
      $display("FAIL %s cam activity: got clash=%0d en=%0d wr=%0d required clash=0 en=%0d wr=%0d",
               tag, clash, n_en, n_wr, e_en, e_wr);
    end
    if (e_wr != 0) begin
      n_cmp++;
      if ({wa, wd} !== {1'b0, e_idx, e_wd}) begin
        n_bad++;
        $display("FAIL %s write target: got addr=%0d data=%h required addr=%0d data=%h",
                 tag, wa, wd, e_idx, e_wd);
      end
    end
  endtask

  // Releases reset and watches the fill sequence.
  task automatic check_init_seq(input string tag);
    int n_wr, first_done, n_rsp, n_en;
    bit seq_ok;
    n_wr = 0; first_done = 0; n_rsp = 0; n_en = 0; seq_ok = 1'b1;
    @(negedge clk);
    rst_n = 1'b1;
    for (int k = 1; k <= 20; k++) begin
      @(negedge clk);
      if (cam_write) begin
        if (cam_addr !== 5'(n_wr) || cam_data !== 8'hFF || k != n_wr + 1) seq_ok = 1'b0;
        n_wr++;
      end
      if (init_done === 1'b1 && first_done == 0) first_done = k;
      if (bus.rsp_valid) n_rsp++;
      if (cam_enable) n_en++;
    end
    n_cmp++;
    if (n_wr != 16) begin n_bad++; $display("FAIL %s fill writes: got %0d required 16", tag, n_wr); end
    n_cmp++;
    if (!seq_ok) begin n_bad++; $display("FAIL %s fill order: got out-of-sequence addr/data required 0..15 with FF", tag); end
    n_cmp++;
    if (first_done != 17) begin n_bad++; $display("FAIL %s init_done cycle: got %0d required 17", tag, first_done); end
    n_cmp++;
    if (n_rsp + n_en != 0) begin n_bad++; $display("FAIL %s idle activity: got rsp=%0d en=%0d required 0", tag, n_rsp, n_en); end
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clk);
    n_cmp++;
    if (out_pack() !== '0) begin n_bad++; $display("FAIL reset outputs: got %h required 0", out_pack()); end
    model_reset();
    check_init_seq("reset");
  endtask

  task automatic test_insert_basic();
    run_op(1'b0, 2'b01, 8'h12, "insert_new");
    run_op(1'b0, 2'b01, 8'h12, "insert_dup");
  endtask

  task automatic test_reserved_key();
    run_op(1'b1, 2'b01, 8'hFF, "reserved_key");
  endtask

  task automatic test_round_robin(input int n_grants, input string tag);
    bit g, e_g, e_hit, e_full, e_err, clash;
    logic [3:0] e_idx;
    logic [7:0] e_wd, wd, fields;
    logic [4:0] wa;
    int e_lat, e_en, e_wr, lat, n_en, n_wr, t;
    @(negedge clk);
    drive_req(1'b0, 1'b1, 2'b00, 8'h12);
    drive_req(1'b1, 1'b1, 2'b00, 8'h99);
    #1;
    for (int n = 0; n < n_grants; n++) begin
      t = 0;
      while (!(bus.req0_ready || bus.req1_ready) && t < 50) begin @(negedge clk); t++; end
      n_cmp++;
      if (t >= 50) begin n_bad++; $display("FAIL %s handshake: no grant within 50 cycles", tag); break; end
      n_cmp++;
      if ((bus.req0_ready && bus.req1_ready) !== 1'b0) begin
        n_bad++; $display("FAIL %s double grant: got both ready required one", tag);
      end
      g   = bus.req1_ready;
      e_g = !model_last;
      n_cmp++;
      if (g !== e_g) begin n_bad++; $display("FAIL %s grant %0d: got req%0d required req%0d", tag, n, g, e_g); end
      model_last = g;
      model_apply(2'b00, g ? 8'h99 : 8'h12, e_hit, e_idx, e_full, e_err, e_lat, e_en, e_wr, e_wd);
      @(posedge clk);
      wait_rsp(lat, n_en, n_wr, clash, wa, wd, fields);
      n_cmp++;
      if ({fields, 4'(lat)} !== {g, e_hit, e_idx, e_full, e_err, 4'(e_lat)}) begin
        n_bad++;
        $display("FAIL %s rsp %0d {fields,lat}: got %b/%0d required %b/%0d", tag, n, fields, lat,
                 {g, e_hit, e_idx, e_full, e_err}, e_lat);
      end
    end
    drive_req(1'b0, 1'b0, 2'b00, 8'h00);
    drive_req(1'b1, 1'b0, 2'b00, 8'h00);
  endtask

  task automatic test_reset_mid_op();
    bit saw_rsp;
    int t;
    saw_rsp = 1'b0;
    @(negedge clk);
    drive_req(1'b0, 1'b1, 2'b01, 8'h34);
    #1;
    t = 0;
    while (!bus.req0_ready && t < 50) begin @(negedge clk); t++; end
    n_cmp++;
    if (t >= 50) begin n_bad++; $display("FAIL mid_reset handshake: ready not seen within 50 cycles"); end
    @(posedge clk);
    #1 drive_req(1'b0, 1'b0, 2'b01, 8'h34);
    @(negedge clk);
    if (bus.rsp_valid) saw_rsp = 1'b1;
    @(negedge clk);
    if (bus.rsp_valid) saw_rsp = 1'b1;
    rst_n = 1'b0;
    #1;
    n_cmp++;
    if (out_pack() !== '0) begin n_bad++; $display("FAIL mid_reset outputs: got %h required 0", out_pack()); end
    repeat (3) begin
      @(negedge clk);
      if (bus.rsp_valid) saw_rsp = 1'b1;
    end
    n_cmp++;
    if (saw_rsp) begin n_bad++; $display("FAIL mid_reset dropped op: got a response required none"); end
    model_reset();
    check_init_seq("mid_reset_reinit");
    test_round_robin(2, "post_reset_tie");
  endtask

  task automatic test_full();
    for (int k = 0; k < 16; k++) run_op(1'b0, 2'b01, 8'(k), "fill_slots");
    run_op(1'b0, 2'b01, 8'h20, "insert_when_full");
    run_op(1'b1, 2'b10, 8'h05, "delete_hit");
    run_op(1'b1, 2'b10, 8'h05, "delete_miss");
    run_op(1'b0, 2'b01, 8'h20, "insert_reuse_slot");
    run_op(1'b1, 2'b00, 8'h20, "lookup_reused");
  endtask

  task automatic test_random();
    logic [7:0] key;
    for (int n = 0; n < 80; n++) begin
      key = ($urandom_range(0, 15) == 0) ? 8'hFF : 8'(8'h20 + $urandom_range(0, 19));
      run_op(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), key, "random");
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end
  endtask

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    drive_req(1'b0, 1'b0, 2'b00, 8'h00);
    drive_req(1'b1, 1'b0, 2'b00, 8'h00);
    test_reset();
    test_insert_basic();
    test_reserved_key();
    test_round_robin(4, "tie");
    test_reset_mid_op();
    test_full();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
